// File: rtl/instr_loader_if.sv
// Byte-stream loader bus: stream input side and instruction-memory write side,
// plus core hold and status flags.
interface instr_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 6
);
  logic                  start_i;
  logic [7:0]            byte_i;
  logic                  byte_valid_i;
  logic                  wr_en_o;
  logic [AW-1:0]         wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  core_hold_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;

  modport master (
    output start_i, byte_i, byte_valid_i,
    input  wr_en_o, wr_addr_o, wr_data_o, core_hold_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, byte_i, byte_valid_i,
    output wr_en_o, wr_addr_o, wr_data_o, core_hold_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/instr_loader.sv
// Program loader: parses a framed byte stream (count, little-endian data words,
// checksum), writes the words into instruction memory and releases the core
// from reset only after a load with a matching checksum.
module instr_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ROM_DEPTH  = 64,
  parameter int AW         = $clog2(ROM_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  instr_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [8:0] DEPTH9 = 9'(ROM_DEPTH);

  state_t                state;
  logic [1:0]            byte_idx;
  logic [AW-1:0]         word_idx;
  logic [AW-1:0]         last_idx;
  logic [7:0]            csum;
  logic [DATA_WIDTH-9:0] word_sr;

  logic                  wr_en_r;
  logic [AW-1:0]         wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic                  core_hold_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;

  logic [8:0]            n_ext;
  logic                  len_bad;
  logic                  take;

  assign n_ext   = {1'b0, bus.byte_i};
  // Count must be 1..ROM_DEPTH; the 9-bit compare covers ROM_DEPTH = 256.
  assign len_bad = (bus.byte_i == 8'd0) || (n_ext > DEPTH9);
  // A byte coinciding with start is discarded.
  assign take    = bus.byte_valid_i && !bus.start_i;

  // Frame FSM with registered write port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_idx    <= 2'd0;
      word_idx    <= '0;
      last_idx    <= '0;
      csum        <= 8'd0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      core_hold_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      if (bus.start_i) begin
        state       <= LEN;
        byte_idx    <= 2'd0;
        word_idx    <= '0;
        csum        <= 8'd0;
        core_hold_r <= 1'b1;
        busy_r      <= 1'b1;
        done_r      <= 1'b0;
        err_r       <= 1'b0;
      end else if (take) begin
        case (state)
          LEN: begin
            csum     <= bus.byte_i;
            byte_idx <= 2'd0;
            word_idx <= '0;
            last_idx <= AW'(bus.byte_i - 8'd1);
            if (len_bad) begin
              state  <= ERR;
              busy_r <= 1'b0;
              err_r  <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            csum     <= csum + bus.byte_i;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wr_en_r   <= 1'b1;
              wr_addr_r <= word_idx;
              wr_data_r <= {bus.byte_i, word_sr};
              // Word index stops at N-1 so the address never wraps.
              if (word_idx == last_idx) begin
                state <= CSUM;
              end else begin
                word_idx <= word_idx + 1'b1;
              end
            end
          end
          CSUM: begin
            busy_r <= 1'b0;
            if (bus.byte_i == csum) begin
              state       <= DONE;
              done_r      <= 1'b1;
              core_hold_r <= 1'b0;
            end else begin
              state <= ERR;
              err_r <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Little-endian byte assembly: bytes enter at the top and shift down, so
  // after three bytes the first one sits in the lowest lane.
  always_ff @(posedge clk) begin
    if (take && state == DATA) begin
      word_sr <= {bus.byte_i, word_sr[DATA_WIDTH-9:8]};
    end
  end

  assign bus.wr_en_o     = wr_en_r;
  assign bus.wr_addr_o   = wr_addr_r;
  assign bus.wr_data_o   = wr_data_r;
  assign bus.core_hold_o = core_hold_r;
  assign bus.busy_o      = busy_r;
  assign bus.done_o      = done_r;
  assign bus.err_o       = err_r;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: frame-level reference model feeds an expected-write
// scoreboard; a monitor pops and compares on every write strobe.
module tb_instr_loader;
  localparam int ROM_DEPTH = 64;
  localparam int AW        = $clog2(ROM_DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  wr_t  exp_q[$];

  always #5 clk = ~clk;

  instr_loader_if #(.DATA_WIDTH(32), .AW(AW)) bus ();

  instr_loader #(.DATA_WIDTH(32), .ROM_DEPTH(ROM_DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.wr_en_o !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h required=no_write",
                 bus.wr_addr_o, bus.wr_data_o);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.wr_addr_o), 64'(e.addr));
        check("wr_data", 64'(bus.wr_data_o), 64'(e.data));
      end
    end
  end

  // Reference model at frame level: returns 0 = still loading, 1 = done, 2 = error,
  // and queues the writes for every complete word present in the byte list.
  task automatic model(input logic [7:0] fr[$], output int st);
    int         n;
    logic [7:0] sum;
    wr_t        w;
    st = 0;
    if (fr.size() == 0) return;
    n   = int'(fr[0]);
    sum = fr[0];
    if (n == 0 || n > ROM_DEPTH) begin
      st = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (fr.size() >= 1 + 4 * (k + 1)) begin
        w.addr = AW'(k);
        w.data = {fr[4*k+4], fr[4*k+3], fr[4*k+2], fr[4*k+1]};
        exp_q.push_back(w);
      end
    end
    for (int i = 1; i <= 4 * n && i < fr.size(); i++) sum = sum + fr[i];
    if (fr.size() > 4 * n + 1) st = (fr[4*n+1] == sum) ? 1 : 2;
  endtask

  task automatic chk_status(input string name, input logic b, input logic h,
                            input logic d, input logic e);
    check({name, "_busy"}, 64'(bus.busy_o), 64'(b));
    check({name, "_hold"}, 64'(bus.core_hold_o), 64'(h));
    check({name, "_done"}, 64'(bus.done_o), 64'(d));
    check({name, "_err"},  64'(bus.err_o), 64'(e));
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'($urandom);
  endtask

  task automatic do_start(input string name);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk_status(name, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] fr[$], input int maxgap, input string name);
    int st;
    model(fr, st);
    foreach (fr[i]) begin
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      send(fr[i]);
    end
    case (st)
      1:       chk_status(name, 1'b0, 1'b0, 1'b1, 1'b0);
      2:       chk_status(name, 1'b0, 1'b1, 1'b0, 1'b1);
      default: chk_status(name, 1'b1, 1'b1, 1'b0, 1'b0);
    endcase
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic build(input logic [31:0] words[$], input bit bad, output logic [7:0] fr[$]);
    logic [7:0] s;
    fr = {};
    fr.push_back(8'(words.size()));
    s = 8'(words.size());
    foreach (words[k]) begin
      for (int j = 0; j < 4; j++) begin
        fr.push_back(words[k][8*j +: 8]);
        s = s + words[k][8*j +: 8];
      end
    end
    fr.push_back(bad ? s + 8'd1 : s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  fr[$];
    logic [31:0] words[$];
    bus.start_i      = 1'b0;
    bus.byte_i       = 8'd0;
    bus.byte_valid_i = 1'b0;
    rst              = 1'b1;
    repeat (3) @(negedge clk);
    chk_status("reset", 1'b0, 1'b1, 1'b0, 1'b0);
    check("reset_wr_en", 64'(bus.wr_en_o), 64'd0);
    check("reset_wr_addr", 64'(bus.wr_addr_o), 64'd0);
    check("reset_wr_data", 64'(bus.wr_data_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Bytes before any start are ignored.
    for (int i = 0; i < 6; i++) send(8'h01);
    chk_status("idle_ignore", 1'b0, 1'b1, 1'b0, 1'b0);

    // Single word.
    do_start("single_start");
    fr = {8'h01, 8'h13, 8'h05, 8'h00, 8'h00, 8'h19};
    run_frame(fr, 0, "single");

    // Bad checksum: write still happens.
    do_start("badcs_start");
    fr = {8'h01, 8'h13, 8'h05, 8'h00, 8'h00, 8'h18};
    run_frame(fr, 2, "badcs");

    // Count errors, followed by bytes that must not be written.
    do_start("n0_start");
    fr = {8'h00};
    run_frame(fr, 0, "n0");
    for (int i = 0; i < 9; i++) send(8'($urandom));
    chk_status("n0_after", 1'b0, 1'b1, 1'b0, 1'b1);
    do_start("nbig_start");
    fr = {8'(ROM_DEPTH + 1)};
    run_frame(fr, 0, "nbig");
    for (int i = 0; i < 9; i++) send(8'($urandom));
    chk_status("nbig_after", 1'b0, 1'b1, 1'b0, 1'b1);

    // Restart mid-frame: 6 data bytes of a 2-word frame, then start with a byte.
    do_start("restart_start");
    fr = {8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_frame(fr, 1, "restart_partial");
    bus.start_i      = 1'b1;
    bus.byte_i       = 8'h01;
    bus.byte_valid_i = 1'b1;
    @(negedge clk);
    bus.start_i      = 1'b0;
    bus.byte_valid_i = 1'b0;
    chk_status("restart_with_byte", 1'b1, 1'b1, 1'b0, 1'b0);
    fr = {8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    fr[5] = 8'h01 + 8'hEF + 8'hBE + 8'hAD + 8'hDE;
    run_frame(fr, 1, "restart_new");

    // Full load with irregular gaps.
    do_start("full_start");
    words = {};
    for (int k = 0; k < ROM_DEPTH; k++) words.push_back(32'hA500_0000 | 32'(k));
    build(words, 1'b0, fr);
    run_frame(fr, 3, "full");

    // Random short frames, some with corrupted checksums, some back-to-back.
    for (int t = 0; t < 8; t++) begin
      do_start("rand_start");
      words = {};
      for (int k = 0; k < int'($urandom_range(4, 1)); k++) words.push_back($urandom);
      build(words, $urandom_range(1, 0) == 1, fr);
      run_frame(fr, (t % 2) * 3, "rand");
    end

    // Async reset mid-load, asserted between clock edges.
    do_start("arst_start");
    fr = {8'h02, 8'h12, 8'h34};
    run_frame(fr, 0, "arst_partial");
    #3;
    rst = 1'b1;
    #1;
    chk_status("arst", 1'b0, 1'b1, 1'b0, 1'b0);
    check("arst_wr_en", 64'(bus.wr_en_o), 64'd0);
    check("arst_wr_addr", 64'(bus.wr_addr_o), 64'd0);
    check("arst_wr_data", 64'(bus.wr_data_o), 64'd0);
    #3;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) send(8'($urandom));
    chk_status("arst_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    check("arst_pending", 64'(exp_q.size()), 64'd0);

    // Loader still works after the reset.
    do_start("post_start");
    fr = {8'h01, 8'h13, 8'h05, 8'h00, 8'h00, 8'h19};
    run_frame(fr, 1, "post");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-stream program loader that is the write side of the instruction memory the core fetches from. It receives a framed program image one byte per strobe (count, data words, checksum) and assembles little-endian 32-bit words. It drives a write port into the instruction memory and holds the core in reset until a load completes with a valid checksum. It sits between the chip input pins and the instruction memory and core reset in the SoC top.

## Interface
- `DATA_WIDTH`, 32: instruction word width; fixed at 32.
- `ROM_DEPTH`, 64: instruction memory depth in words; power of two, 2..256.
- `AW`, `$clog2(ROM_DEPTH)`: write address width (derived).

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: begin or restart a load. Level-sampled; each cycle it is high restarts.
- `byte_i` in 8: stream byte.
- `byte_valid_i` in 1: `byte_i` is accepted on each edge where this is high. No backpressure.
- `wr_en_o` out 1: instruction-memory write strobe, one cycle per word.
- `wr_addr_o` out AW: word address for the write.
- `wr_data_o` out 32: word to write.
- `core_hold_o` out 1: high holds the core in reset.
- `busy_o` out 1: load in progress.
- `done_o` out 1: last load succeeded.
- `err_o` out 1: last load failed.

## Operation
- **Frame format:** count byte N (words), then 4·N data bytes, then one checksum byte.
  - Checksum = (N + sum of all data bytes) mod 256.
  - Data is little-endian: the first byte of each word goes to [7:0], the fourth to [31:24].
- **States:** IDLE, LEN, DATA, CSUM, DONE, ERR.
- **IDLE** (post-reset): bytes are ignored; `core_hold_o`=1. `start_i` → LEN.
- **LEN:** on an accepted byte, latch N and seed the checksum with N.
  - N=0 or N>ROM_DEPTH → ERR.
  - Otherwise → DATA. Clear the byte index (0..3) and the word index.
- **DATA:** each accepted byte is shifted into the word register and added to the checksum.
  - On the 4th byte: issue a write (see Timing), increment the word index, reset the byte index.
  - After word N−1 is written → CSUM.
- **CSUM:** on an accepted byte, compare it with the running checksum. Equal → DONE, else → ERR.
- **DONE:** `core_hold_o`=0, `done_o`=1; bytes are ignored.
- **ERR:** `core_hold_o`=1, `err_o`=1; bytes are ignored. Words already written stay in memory; there is no rollback.
- **`start_i` in any state:** next state is LEN.
  - Byte index, word index and checksum are cleared; `done_o` and `err_o` are cleared.
  - A byte presented in the same cycle is discarded.
- `busy_o`=1 exactly in LEN, DATA and CSUM.
- `core_hold_o`=0 only in DONE.
- The checksum is an 8-bit wrap-around accumulator. The word index never exceeds N−1, so `wr_addr_o` cannot wrap.

## Timing
- **Reset values:**
  - state IDLE
  - `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0
  - `core_hold_o`=1, `busy_o`=0, `done_o`=0, `err_o`=0
- All outputs are registered; there is no combinational path from inputs to outputs.
- `wr_en_o` is high for exactly the one cycle after the edge that accepts the 4th byte of a word. `wr_addr_o` and `wr_data_o` are valid in that cycle and hold their values afterwards.
- Back-to-back bytes (`byte_valid_i` high every cycle) are fully supported. Writes are then spaced 4 cycles apart. Gaps of any length between bytes are allowed.
- DONE/ERR outputs appear the cycle after the edge that accepts the checksum byte, or the count byte for an N error.
- `start_i` takes effect on the next edge: `busy_o`=1 and `core_hold_o`=1 from the following cycle.
  - A `wr_en_o` pulse already registered in that cycle still completes.
  - No further writes occur from the aborted frame.
- `rst` mid-load: all outputs return to their reset values immediately (async). The partial frame is discarded.

## Test plan
- **Single word:** start; bytes 0x01, 0x13, 0x05, 0x00, 0x00, checksum 0x19 → one `wr_en_o` pulse with addr 0, data 0x00000513; then `done_o`=1, `core_hold_o`=0.
- **Full load with irregular gaps:** N=ROM_DEPTH, word k = 0xA5000000|k, random idle cycles between bytes, correct checksum → exactly ROM_DEPTH writes at addresses 0..ROM_DEPTH−1 with matching data; DONE.
- **Bad checksum:** same 1-word frame with checksum 0x18 → write still occurs at addr 0; then `err_o`=1, `core_hold_o`=1, `done_o`=0.
- **Count errors:**
  - N=0 → ERR the cycle after the count byte; the following bytes produce no writes.
  - N=ROM_DEPTH+1 → same behaviour.
- **Restart mid-frame:** start; N=2; send 6 data bytes; assert `start_i` together with a byte; send a valid 1-word frame → only addr 0 is written by the new frame, no addr 1 write; DONE.
- **Async reset mid-load:** `rst` pulse after 2 data bytes, including a pulse that is not aligned to `clk` → outputs at reset values immediately; state IDLE; bytes ignored until `start_i`.
